// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: turn sequencer for the two-player memory game; issues pick/pause/end-turn strobes,
// runs the per-turn countdown and decides end of game and winner.
module game_turn_ctrl #(
  parameter int TURN_SECONDS = 15,
  parameter int N_PAIRS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_sel_i,
  input  logic       tick_1s_i,
  input  logic       card_down_at_hi_i,
  input  logic       cards_match_i,
  input  logic       pause_done_i,
  input  logic       auto_pick1_valid_i,
  input  logic       auto_pick2_valid_i,
  input  logic [3:0] p1_score_i,
  input  logic [3:0] p2_score_i,
  output logic       select_first_o,
  output logic       select_second_o,
  output logic       auto_first_o,
  output logic       auto_second_o,
  output logic       start_pause_o,
  output logic       end_turn_o,
  output logic [3:0] time_left_o,
  output logic [2:0] state_o,
  output logic       game_over_o,
  output logic [1:0] winner_o
);
  typedef enum logic [2:0] {PICK1 = 3'd0, PICK2 = 3'd1, EVAL = 3'd2, PAUSE = 3'd3, CHECK = 3'd4, OVER = 3'd5} state_t;
  localparam logic [3:0] RELOAD = 4'(TURN_SECONDS);
  state_t st;
  logic [3:0] time_q;
  logic match_q, nocard_q, in_pick, press, timeout;
  logic [4:0] sum;
  assign in_pick = st == PICK1 || st == PICK2;
  assign press = btn_sel_i && card_down_at_hi_i;
  assign timeout = in_pick && tick_1s_i && time_q == 4'd1;
  assign sum = {1'b0, p1_score_i} + {1'b0, p2_score_i};
  // strobes are gated by rst_n so nothing leaks out while reset is held
  assign select_first_o  = rst_n && st == PICK1 && press;
  assign auto_first_o    = rst_n && st == PICK1 && !press && timeout && auto_pick1_valid_i;
  assign select_second_o = rst_n && st == PICK2 && press;
  assign auto_second_o   = rst_n && st == PICK2 && !press && timeout && auto_pick2_valid_i;
  assign start_pause_o   = rst_n && st == EVAL && !match_q;
  assign end_turn_o      = rst_n && ((st == PICK2 && !press && timeout && !auto_pick2_valid_i) ||
                                     (st == PAUSE && pause_done_i));
  assign time_left_o = time_q;
  assign state_o = st;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= PICK1;
      time_q <= RELOAD;
      match_q <= 1'b0;
      nocard_q <= 1'b0;
      game_over_o <= 1'b0;
      winner_o <= 2'b00;
    end else begin
      if (in_pick && tick_1s_i && !press && time_q != 4'd0) time_q <= time_q - 4'd1;
      case (st)
        PICK1:
          if (press) st <= PICK2;
          else if (timeout) begin
            if (auto_pick1_valid_i) begin
              st <= PICK2;
              // an expired first pick leaves no budget, so the second pick gets a fresh one
              time_q <= RELOAD;
            end else begin
              st <= CHECK;
              nocard_q <= 1'b1;
            end
          end
        PICK2:
          if (press || (timeout && auto_pick2_valid_i)) begin
            match_q <= cards_match_i;
            st <= EVAL;
          end else if (timeout) begin
            time_q <= RELOAD;
            st <= PICK1;
          end
        EVAL: st <= match_q ? CHECK : PAUSE;
        PAUSE:
          if (pause_done_i) begin
            time_q <= RELOAD;
            st <= PICK1;
          end
        CHECK:
          if (sum >= 5'(N_PAIRS) || nocard_q) begin
            st <= OVER;
            game_over_o <= 1'b1;
            winner_o <= p1_score_i > p2_score_i ? 2'b01 : p2_score_i > p1_score_i ? 2'b10 : 2'b11;
          end else begin
            time_q <= RELOAD;
            st <= PICK1;
          end
        default: st <= OVER;
      endcase
    end
  end
endmodule

// File: tb/tb_game_turn_ctrl.sv
// tb_game_turn_ctrl: directed self-checking bench for game_turn_ctrl.
module tb_game_turn_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic btn = 1'b0, tick = 1'b0, down = 1'b1, cm = 1'b0, pd = 1'b0, av1 = 1'b1, av2 = 1'b1;
  logic [3:0] p1 = 4'd0, p2 = 4'd0;
  logic sel1, sel2, a1, a2, sp, et, go;
  logic [3:0] tl;
  logic [2:0] st;
  logic [1:0] win;
  logic [5:0] str;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  assign str = {sel1, sel2, a1, a2, sp, et};
  game_turn_ctrl dut (
    .clk(clk), .rst_n(rst_n), .btn_sel_i(btn), .tick_1s_i(tick), .card_down_at_hi_i(down),
    .cards_match_i(cm), .pause_done_i(pd), .auto_pick1_valid_i(av1), .auto_pick2_valid_i(av2),
    .p1_score_i(p1), .p2_score_i(p2), .select_first_o(sel1), .select_second_o(sel2),
    .auto_first_o(a1), .auto_second_o(a2), .start_pause_o(sp), .end_turn_o(et),
    .time_left_o(tl), .state_o(st), .game_over_o(go), .winner_o(win)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic pulse(input logic b, input logic t, input logic p, input logic [5:0] exp, input string tag);
    btn = b;
    tick = t;
    pd = p;
    #1 chk(tag, 8'(str), 8'(exp));
    @(posedge clk);
    #1;
    btn = 1'b0;
    tick = 1'b0;
    pd = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1, 1'b0, 6'b0, "tick_quiet");
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    btn = 1'b1;
    #12;
    chk("rst_state", 8'(st), 8'd0);
    chk("rst_time", 8'(tl), 8'd15);
    chk("rst_over", 8'(go), 8'd0);
    chk("rst_winner", 8'(win), 8'd0);
    chk("rst_strobes", 8'(str), 8'd0);
    btn = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pulse(1, 0, 0, 6'b100000, "miss_sel1");
    chk("miss_st1", 8'(st), 8'd1);
    cm = 1'b0;
    pulse(1, 0, 0, 6'b010000, "miss_sel2");
    chk("miss_st_eval", 8'(st), 8'd2);
    pulse(0, 1, 0, 6'b000010, "miss_pause");
    chk("miss_st_pause", 8'(st), 8'd3);
    pulse(0, 0, 0, 6'b000000, "miss_hold");
    pulse(0, 0, 1, 6'b000001, "miss_end");
    chk("miss_st0", 8'(st), 8'd0);
    chk("miss_time", 8'(tl), 8'd15);
    ticks(2);
    chk("tick_dec", 8'(tl), 8'd13);
    pulse(1, 0, 0, 6'b100000, "match_sel1");
    cm = 1'b1;
    pulse(1, 1, 0, 6'b010000, "match_sel2");
    chk("match_time_frozen", 8'(tl), 8'd13);
    p1 = 4'd1;
    pulse(0, 0, 0, 6'b000000, "match_eval");
    chk("match_st_check", 8'(st), 8'd4);
    pulse(0, 0, 0, 6'b000000, "match_check");
    chk("match_st0", 8'(st), 8'd0);
    chk("match_time", 8'(tl), 8'd15);
    cm = 1'b0;
    ticks(14);
    chk("to_time1", 8'(tl), 8'd1);
    pulse(0, 1, 0, 6'b001000, "to_auto1");
    chk("to_st1", 8'(st), 8'd1);
    chk("to_time_pick2", 8'(tl), 8'd15);
    ticks(14);
    chk("to_time1b", 8'(tl), 8'd1);
    pulse(0, 1, 0, 6'b000100, "to_auto2");
    chk("to_st_eval", 8'(st), 8'd2);
    pulse(0, 0, 0, 6'b000010, "to_pause");
    pulse(0, 0, 1, 6'b000001, "to_end");
    chk("to_st0", 8'(st), 8'd0);
    ticks(14);
    pulse(1, 1, 0, 6'b100000, "bvt_sel1");
    chk("bvt_time", 8'(tl), 8'd1);
    chk("bvt_st", 8'(st), 8'd1);
    av2 = 1'b0;
    pulse(0, 1, 0, 6'b000001, "nov2_end");
    chk("nov2_st", 8'(st), 8'd0);
    chk("nov2_time", 8'(tl), 8'd15);
    av2 = 1'b1;
    down = 1'b0;
    pulse(1, 0, 0, 6'b000000, "faceup_ignored");
    chk("faceup_st", 8'(st), 8'd0);
    down = 1'b1;
    p1 = 4'd4;
    p2 = 4'd3;
    pulse(1, 0, 0, 6'b100000, "end1_sel1");
    cm = 1'b1;
    pulse(1, 0, 0, 6'b010000, "end1_sel2");
    p1 = 4'd5;
    pulse(0, 0, 0, 6'b000000, "end1_eval");
    pulse(0, 0, 0, 6'b000000, "end1_check");
    chk("end1_st", 8'(st), 8'd5);
    chk("end1_over", 8'(go), 8'd1);
    chk("end1_winner", 8'(win), 8'd1);
    pulse(1, 1, 1, 6'b000000, "end1_absorb");
    chk("end1_st_hold", 8'(st), 8'd5);
    do_reset();
    chk("rst2_over", 8'(go), 8'd0);
    p1 = 4'd4;
    p2 = 4'd3;
    pulse(1, 0, 0, 6'b100000, "end2_sel1");
    pulse(1, 0, 0, 6'b010000, "end2_sel2");
    p2 = 4'd4;
    pulse(0, 0, 0, 6'b000000, "end2_eval");
    pulse(0, 0, 0, 6'b000000, "end2_check");
    chk("end2_st", 8'(st), 8'd5);
    chk("end2_winner", 8'(win), 8'd3);
    do_reset();
    p1 = 4'd0;
    p2 = 4'd0;
    cm = 1'b0;
    pulse(1, 0, 0, 6'b100000, "rp_sel1");
    pulse(1, 0, 0, 6'b010000, "rp_sel2");
    pulse(0, 0, 0, 6'b000010, "rp_pause");
    chk("rp_st_pause", 8'(st), 8'd3);
    rst_n = 1'b0;
    pd = 1'b1;
    #2;
    chk("rp_st", 8'(st), 8'd0);
    chk("rp_time", 8'(tl), 8'd15);
    chk("rp_strobes", 8'(str), 8'd0);
    rst_n = 1'b1;
    pd = 1'b0;
    @(posedge clk);
    #1;
    pulse(0, 0, 1, 6'b000000, "rp_pd_after");
    chk("rp_st_after", 8'(st), 8'd0);
    p2 = 4'd2;
    av1 = 1'b0;
    ticks(14);
    pulse(0, 1, 0, 6'b000000, "nc_timeout");
    chk("nc_st_check", 8'(st), 8'd4);
    pulse(0, 0, 0, 6'b000000, "nc_check");
    chk("nc_st_over", 8'(st), 8'd5);
    chk("nc_winner", 8'(win), 8'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
